// File: rtl/mult_pattern_arbiter_if.sv
// Request/response/config bundle for the shared multiply-and-pattern-detect pipeline.
// slave = the arbiter side, master = the requesters/consumer side.
interface mult_pattern_arbiter_if #(
    parameter int DW   = 8,
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_a;
    logic [NREQ*DW-1:0] req_b;
    logic               resp_valid;
    logic               resp_ready;
    logic [IDW-1:0]     resp_id;
    logic [2*DW-1:0]    resp_product;
    logic               resp_match;
    logic               cfg_we;
    logic [2*DW-1:0]    cfg_pattern;
    logic [15:0]        match_cnt;
    logic               cnt_clr;

    modport slave (
        input  req_valid, req_a, req_b, resp_ready, cfg_we, cfg_pattern, cnt_clr,
        output req_ready, resp_valid, resp_id, resp_product, resp_match, match_cnt
    );

    modport master (
        output req_valid, req_a, req_b, resp_ready, cfg_we, cfg_pattern, cnt_clr,
        input  req_ready, resp_valid, resp_id, resp_product, resp_match, match_cnt
    );
endinterface

// File: rtl/mult_pattern_arbiter.sv
// Round-robin arbiter feeding a 2-stage multiply + pattern-compare pipeline,
// with a writable pattern register and a saturating match counter.
module mult_pattern_arbiter #(
    parameter int              DW      = 8,
    parameter int              NREQ    = 4,
    parameter int              IDW     = 2,
    parameter logic [2*DW-1:0] PATTERN = 18
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mult_pattern_arbiter_if.slave  bus
);
    logic            r_s1_valid;
    logic [DW-1:0]   r_s1_a;
    logic [DW-1:0]   r_s1_b;
    logic [IDW-1:0]  r_s1_id;
    logic            r_out_valid;
    logic [IDW-1:0]  r_out_id;
    logic [2*DW-1:0] r_out_product;
    logic            r_out_match;
    logic [2*DW-1:0] r_pattern;
    logic [15:0]     r_match_cnt;
    logic [IDW-1:0]  r_rr_ptr;

    logic            w_stall;
    logic            w_found;
    logic            w_transfer;
    logic            w_accept;
    logic [IDW-1:0]  w_win_id;
    logic [IDW:0]    w_win_inc;
    logic [IDW-1:0]  w_next_ptr;
    logic [NREQ-1:0] w_grant;
    logic [2*DW-1:0] w_product;
    logic [IDW:0]    w_sum  [NREQ];
    logic [IDW-1:0]  w_cand [NREQ];

    assign w_stall  = r_out_valid & ~bus.resp_ready;
    assign w_accept = r_out_valid & bus.resp_ready;

    // w_cand[gi] is the requester examined gi-th when searching from r_rr_ptr
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
        assign w_sum[gi]  = {1'b0, r_rr_ptr} + (IDW+1)'(gi);
        assign w_cand[gi] = (w_sum[gi] >= (IDW+1)'(NREQ)) ? IDW'(w_sum[gi] - (IDW+1)'(NREQ))
                                                          : w_sum[gi][IDW-1:0];
    end

    always_comb begin
        w_found  = 1'b0;
        w_win_id = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && bus.req_valid[w_cand[k]]) begin
                w_found  = 1'b1;
                w_win_id = w_cand[k];
            end
        end
    end

    assign w_transfer = w_found & ~w_stall;
    assign w_win_inc  = {1'b0, w_win_id} + 1'b1;
    assign w_next_ptr = (w_win_inc == (IDW+1)'(NREQ)) ? '0 : w_win_inc[IDW-1:0];

    always_comb begin
        w_grant = '0;
        if (w_transfer) w_grant[w_win_id] = 1'b1;
    end

    assign w_product = (2*DW)'(r_s1_a) * (2*DW)'(r_s1_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid    <= 1'b0;
            r_s1_a        <= '0;
            r_s1_b        <= '0;
            r_s1_id       <= '0;
            r_out_valid   <= 1'b0;
            r_out_id      <= '0;
            r_out_product <= '0;
            r_out_match   <= 1'b0;
            r_rr_ptr      <= '0;
        end else if (!w_stall) begin
            r_s1_valid <= w_transfer;
            if (w_transfer) begin
                r_s1_a   <= bus.req_a[w_win_id*DW +: DW];
                r_s1_b   <= bus.req_b[w_win_id*DW +: DW];
                r_s1_id  <= w_win_id;
                r_rr_ptr <= w_next_ptr;
            end
            // Compare uses the pattern as it stands before any write at this edge
            r_out_valid   <= r_s1_valid;
            r_out_id      <= r_s1_id;
            r_out_product <= w_product;
            r_out_match   <= (w_product == r_pattern);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pattern <= PATTERN;
        end else if (bus.cfg_we) begin
            r_pattern <= bus.cfg_pattern;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_match_cnt <= '0;
        end else if (bus.cnt_clr) begin
            r_match_cnt <= '0;
        end else if (w_accept && r_out_match && (r_match_cnt != 16'hFFFF)) begin
            r_match_cnt <= r_match_cnt + 16'd1;
        end
    end

    assign bus.req_ready    = w_grant;
    assign bus.resp_valid   = r_out_valid;
    assign bus.resp_id      = r_out_id;
    assign bus.resp_product = r_out_product;
    assign bus.resp_match   = r_out_match;
    assign bus.match_cnt    = r_match_cnt;
endmodule

// File: tb/tb_mult_pattern_arbiter.sv
// Scoreboard bench: a request-level model predicts grants and results, a
// separate monitor compares them against what the arbiter presents.
module tb_mult_pattern_arbiter;
    localparam int DW   = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    typedef struct {
        logic [IDW-1:0]  id;
        logic [2*DW-1:0] prod;
        logic            match;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mult_pattern_arbiter_if #(.DW(DW), .NREQ(NREQ), .IDW(IDW)) bus ();

    mult_pattern_arbiter #(.DW(DW), .NREQ(NREQ), .IDW(IDW), .PATTERN(16'd18)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // model state
    exp_t            exp_q[$];
    logic [NREQ-1:0] exp_ready;
    int              m_rr;
    logic [2*DW-1:0] m_pattern;
    logic            pend_v;
    logic [IDW-1:0]  pend_id;
    logic [2*DW-1:0] pend_prod;

    // monitor state
    int              n_cmp = 0;
    int              n_err = 0;
    logic [15:0]     m_cnt;
    logic            prev_stall;
    logic [IDW-1:0]  held_id;
    logic [2*DW-1:0] held_prod;
    logic            held_match;
    logic            done  = 1'b0;
    logic            quiet = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, expv, $time);
        end
    endtask

    // Model: the winner is the first valid requester at or after the pointer;
    // a granted op is judged against the pattern in force when it leaves S1.
    initial begin
        int win;
        logic stall;
        logic [DW-1:0] op_a, op_b;
        m_rr = 0; m_pattern = 16'd18; pend_v = 1'b0; exp_ready = '0;
        pend_id = '0; pend_prod = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                m_rr = 0; m_pattern = 16'd18; pend_v = 1'b0; exp_ready = '0;
                exp_q.delete();
            end else begin
                stall = bus.resp_valid && !bus.resp_ready;
                win = -1;
                for (int k = 0; k < NREQ; k++)
                    if (win < 0 && bus.req_valid[(m_rr + k) % NREQ]) win = (m_rr + k) % NREQ;
                exp_ready = '0;
                if (!stall && win >= 0) exp_ready[win] = 1'b1;
                if (!stall) begin
                    if (pend_v) exp_q.push_back('{pend_id, pend_prod, pend_prod == m_pattern});
                    pend_v = (win >= 0);
                    if (win >= 0) begin
                        op_a      = bus.req_a[win*DW +: DW];
                        op_b      = bus.req_b[win*DW +: DW];
                        pend_id   = IDW'(win);
                        pend_prod = (2*DW)'(op_a) * (2*DW)'(op_b);
                        m_rr      = (win + 1) % NREQ;
                    end
                end
                if (bus.cfg_we) m_pattern = bus.cfg_pattern;
            end
        end
    end

    // Monitor: compares grants, counter, held outputs and popped results
    initial begin
        exp_t e;
        logic acc_match;
        m_cnt = '0; prev_stall = 1'b0;
        held_id = '0; held_prod = '0; held_match = 1'b0;
        while (!done) begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                check("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
                check("reset_match_cnt", 32'(bus.match_cnt), 32'd0);
                m_cnt = '0;
                prev_stall = 1'b0;
            end else begin
                check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
                check("match_cnt", 32'(bus.match_cnt), 32'(m_cnt));
                if (prev_stall) begin
                    check("hold_valid", 32'(bus.resp_valid), 32'd1);
                    check("hold_id", 32'(bus.resp_id), 32'(held_id));
                    check("hold_product", 32'(bus.resp_product), 32'(held_prod));
                    check("hold_match", 32'(bus.resp_match), 32'(held_match));
                end
                acc_match = 1'b0;
                if (bus.resp_valid && bus.resp_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_resp", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_id", 32'(bus.resp_id), 32'(e.id));
                        check("resp_product", 32'(bus.resp_product), 32'(e.prod));
                        check("resp_match", 32'(bus.resp_match), 32'(e.match));
                        acc_match = e.match;
                        if (!quiet)
                            $display("resp id=%0d product=%0d match=%0d (exp id=%0d product=%0d match=%0d)",
                                     bus.resp_id, bus.resp_product, bus.resp_match, e.id, e.prod, e.match);
                    end
                end
                if (bus.cnt_clr) m_cnt = '0;
                else if (acc_match && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                prev_stall = bus.resp_valid && !bus.resp_ready;
                held_id    = bus.resp_id;
                held_prod  = bus.resp_product;
                held_match = bus.resp_match;
            end
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        check("drain_pipe_empty", 32'(pend_v), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.req_a[i*DW +: DW] = a;
        bus.req_b[i*DW +: DW] = b;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++)
            set_op(i, DW'($urandom_range(0, 15)), DW'($urandom_range(0, 15)));
    endtask

    // Stimulus
    initial begin
        int wait_cnt;
        rst_n = 1'b0;
        bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0;
        bus.resp_ready = 1'b1; bus.cfg_we = 1'b0; bus.cfg_pattern = '0; bus.cnt_clr = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // single op: 3*6 matches the reset pattern
        bus.req_valid = 4'b0001; set_op(0, 8'd3, 8'd6);
        step();
        bus.req_valid = '0;
        repeat (4) step();

        // round robin, everyone requesting
        for (int c = 0; c < 8; c++) begin
            bus.req_valid = 4'hF; rand_ops();
            step();
        end
        bus.req_valid = '0;
        repeat (4) step();

        // backpressure
        bus.req_valid = 4'hF; rand_ops();
        repeat (2) step();
        bus.resp_ready = 1'b0;
        repeat (3) step();
        bus.resp_ready = 1'b1;
        repeat (4) step();
        bus.req_valid = '0;
        repeat (4) step();

        // pattern write while a 10*10 op sits in S1, then a repeat of the op
        bus.req_valid = 4'b0010; set_op(1, 8'd10, 8'd10);
        step();
        bus.req_valid = '0; bus.cfg_we = 1'b1; bus.cfg_pattern = 16'h0064;
        step();
        bus.cfg_we = 1'b0;
        step();
        bus.req_valid = 4'b0010;
        step();
        bus.req_valid = '0;
        repeat (4) step();

        // random traffic with stalls, pattern writes and clears
        for (int c = 0; c < 400; c++) begin
            bus.req_valid  = NREQ'($urandom_range(0, 15));
            rand_ops();
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            bus.cfg_we     = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0: bus.cfg_pattern = 16'd18;
                1: bus.cfg_pattern = 16'd100;
                2: bus.cfg_pattern = 16'd36;
                default: bus.cfg_pattern = 16'($urandom_range(0, 225));
            endcase
            bus.cnt_clr    = ($urandom_range(0, 39) == 0);
            step();
        end
        bus.cfg_we = 1'b0; bus.cnt_clr = 1'b0; bus.resp_ready = 1'b1;

        // reset in the middle of a busy stream
        bus.req_valid = 4'hF;
        for (int c = 0; c < 3; c++) begin
            rand_ops();
            step();
        end
        #1 rst_n = 1'b0;
        bus.req_valid = '0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();

        // counter saturation, then clear while matches keep arriving
        quiet = 1'b1;
        bus.req_valid = 4'hF;
        for (int i = 0; i < NREQ; i++) set_op(i, 8'd3, 8'd6);
        repeat (65600) step();
        quiet = 1'b0;
        bus.cnt_clr = 1'b1;
        step();
        bus.cnt_clr = 1'b0;
        repeat (3) step();

        // drain
        bus.req_valid = '0;
        wait_cnt = 0;
        while ((exp_q.size() != 0 || pend_v) && wait_cnt < 50) begin
            step();
            wait_cnt++;
        end
        repeat (3) step();
        done = 1'b1;
    end
endmodule
